// File: rtl/stopwatch_pkg.sv
// Shared stopwatch display definitions: active-high 7-segment glyphs ordered {g,f,e,d,c,b,a}
// and the helper that applies pin polarity.
package stopwatch_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Active-high in, pin level out; 8 bits covers {dp, segments} and up to 8 anodes.
  function automatic logic [7:0] apply_polarity(input logic [7:0] val, input logic active_low);
    return active_low ? ~val : val;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Hex nibble to active-high 7-segment glyph, {g,f,e,d,c,b,a}.
module seg7_decoder
  import stopwatch_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_OFF;
    unique case (nibble)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = SEG_A;
      4'hB: pattern = SEG_B;
      4'hC: pattern = SEG_C;
      4'hD: pattern = SEG_D;
      4'hE: pattern = SEG_E;
      4'hF: pattern = SEG_F;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 7-segment scanner: snapshots the digit chain once per frame and
// drives one digit per slot, with a blanking gap at each digit switch.
module seven_seg_scanner
  import stopwatch_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIGIT_BITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic [NUM_DIGITS*DIGIT_BITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]            dp_mask,
  input  logic [NUM_DIGITS-1:0]            blank_mask,
  output logic [NUM_DIGITS-1:0]            anode,
  output logic [6:0]                       segments,
  output logic                             dp,
  output logic                             frame_done
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned EXT_W = (DIGIT_BITS > 4) ? DIGIT_BITS : 4;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  localparam logic [NUM_DIGITS-1:0] ANODE_INACTIVE = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]            SEG_INACTIVE   = {7{ACTIVE_LOW}};

  logic [CNT_W-1:0]                 scan_cnt;
  logic [IDX_W-1:0]                 idx;
  logic [NUM_DIGITS*DIGIT_BITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]            snap_dp;
  logic [NUM_DIGITS-1:0]            snap_blank;

  logic [DIGIT_BITS-1:0] digit_sel;
  logic [EXT_W-1:0]      digit_ext;
  logic [3:0]            nibble;
  logic [6:0]            glyph;
  logic                  show;
  logic [NUM_DIGITS-1:0] anode_hi;
  logic [6:0]            seg_hi;
  logic                  dp_hi;
  logic [7:0]            pol_seg_dp;
  logic [7:0]            pol_anode;
  logic [NUM_DIGITS-1:0] anode_d;
  logic [6:0]            segments_d;
  logic                  dp_d;
  logic                  last_cnt;
  logic                  frame_start;

  // Narrow digits are zero-extended; wide digits only contribute their low nibble.
  always_comb begin
    digit_sel = snap_digits[32'(idx) * DIGIT_BITS +: DIGIT_BITS];
    digit_ext = EXT_W'(digit_sel);
    nibble    = digit_ext[3:0];
  end

  seg7_decoder u_decoder (
    .nibble  (nibble),
    .pattern (glyph)
  );

  always_comb begin
    last_cnt    = (scan_cnt == CNT_LAST);
    frame_start = (scan_cnt == '0) && (idx == '0);
    show        = (scan_cnt >= CNT_BLANK) && !snap_blank[idx];
    anode_hi    = show ? (NUM_DIGITS'(1) << idx) : '0;
    seg_hi      = show ? glyph : SEG_OFF;
    dp_hi       = show & snap_dp[idx];
    pol_seg_dp  = apply_polarity({dp_hi, seg_hi}, ACTIVE_LOW);
    pol_anode   = apply_polarity(8'(anode_hi), ACTIVE_LOW);
    anode_d     = pol_anode[NUM_DIGITS-1:0];
    segments_d  = pol_seg_dp[6:0];
    dp_d        = pol_seg_dp[7];
  end

  // Disable behaves exactly like reset so a re-enable always starts a fresh frame.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      scan_cnt    <= '0;
      idx         <= '0;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_blank  <= '0;
      anode       <= ANODE_INACTIVE;
      segments    <= SEG_INACTIVE;
      dp          <= ACTIVE_LOW;
      frame_done  <= 1'b0;
    end else begin
      if (frame_start) begin
        snap_digits <= digits;
        snap_dp     <= dp_mask;
        snap_blank  <= blank_mask;
      end

      anode      <= anode_d;
      segments   <= segments_d;
      dp         <= dp_d;
      frame_done <= last_cnt && (idx == IDX_LAST);

      if (last_cnt) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: per-cycle comparison against a frame-position
// model plus directed literal checks, followed by randomized traffic.
module tb_seven_seg_scanner;

  localparam int ND  = 4;
  localparam int RD  = 4;
  localparam int BC  = 1;
  localparam int FRM = ND * RD;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [15:0]   digits;
  logic [3:0]    dp_mask;
  logic [3:0]    blank_mask;
  logic [3:0]    anode;
  logic [6:0]    segments;
  logic          dp;
  logic          frame_done;

  int compared   = 0;
  int mismatched = 0;
  bit chk_on     = 1'b0;

  // Active-low glyphs, hand-derived from lit segments of each hex character.
  logic [6:0] glyph_al [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seven_seg_scanner #(
    .NUM_DIGITS   (ND),
    .DIGIT_BITS   (4),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .digits     (digits),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .anode      (anode),
    .segments   (segments),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Model: t = enabled cycles since the scan (re)started; position in frame decides output.
  int         t = 0;
  logic [15:0] s_dig = '0;
  logic [3:0]  s_dp = '0;
  logic [3:0]  s_bl = '0;
  logic [3:0]  exp_an = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dp = 1'b1;
  logic        exp_fd = 1'b0;

  always @(posedge clk) begin
    int p, slot, w;
    if (rst || !enable) begin
      t = 0; s_dig = '0; s_dp = '0; s_bl = '0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
    end else begin
      p = t % FRM;
      slot = p / RD;
      w = p % RD;
      if (p == 0) begin
        s_dig = digits; s_dp = dp_mask; s_bl = blank_mask;
      end
      if (w < BC || s_bl[slot]) begin
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      end else begin
        exp_an  = ~(4'b0001 << slot);
        exp_seg = glyph_al[(s_dig >> (4 * slot)) & 16'hF];
        exp_dp  = ~s_dp[slot];
      end
      exp_fd = (p == FRM - 1);
      t++;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      compared++;
      if (anode !== exp_an || segments !== exp_seg || dp !== exp_dp
          || frame_done !== exp_fd) begin
        mismatched++;
        $display("FAIL model @%0t: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                 $time, anode, segments, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
      end
      compared++;
      if ($countones(~anode) > 1 || $isunknown(anode)) begin
        mismatched++;
        $display("FAIL onehot @%0t: got an=%b, want at most one low anode", $time, anode);
      end
    end
  end

  task automatic check_lit(input string name, input logic [3:0] an, input logic [6:0] seg,
                           input logic dpv, input logic fd);
    compared++;
    if (anode !== an || segments !== seg || dp !== dpv || frame_done !== fd) begin
      mismatched++;
      $display("FAIL %s: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
               name, anode, segments, dp, frame_done, an, seg, dpv, fd);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; digits = 16'hABCD; dp_mask = 4'hF; blank_mask = 4'h0;
    @(posedge clk);
    chk_on = 1'b1;
    // Reset holds all outputs inactive.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_lit("reset", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    end

    // Basic scan of 1234.
    rst = 1'b0; enable = 1'b1; digits = 16'h1234; dp_mask = '0; blank_mask = '0;
    step(1);
    check_lit("slot0_blank", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    step(1);
    check_lit("slot0_4", 4'b1110, 7'b0011001, 1'b1, 1'b0);
    step(4);
    check_lit("slot1_3", 4'b1101, 7'b0110000, 1'b1, 1'b0);
    step(4);
    check_lit("slot2_2", 4'b1011, 7'b0100100, 1'b1, 1'b0);
    digits = 16'h9999;  // mid-frame change must not tear the display
    step(4);
    check_lit("slot3_1", 4'b0111, 7'b1111001, 1'b1, 1'b0);
    step(2);
    check_lit("frame_done", 4'b0111, 7'b1111001, 1'b1, 1'b1);
    step(2);
    check_lit("next_frame_9", 4'b1110, 7'b0010000, 1'b1, 1'b0);

    // Masks: fresh frame via a one-cycle disable.
    enable = 1'b0; digits = 16'h0590; dp_mask = 4'b0100; blank_mask = 4'b1000;
    step(1);
    check_lit("disabled", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    enable = 1'b1;
    step(2);
    check_lit("mask_slot0_0", 4'b1110, 7'b1000000, 1'b1, 1'b0);
    step(8);
    check_lit("mask_slot2_5dp", 4'b1011, 7'b0010010, 1'b0, 1'b0);
    step(4);
    check_lit("mask_slot3_blank", 4'b1111, 7'b1111111, 1'b1, 1'b0);

    // Enable drop in slot 1 of the next frame.
    step(8);
    check_lit("pre_drop_slot1_9", 4'b1101, 7'b0010000, 1'b1, 1'b0);
    enable = 1'b0; digits = 16'h0007; dp_mask = '0; blank_mask = '0;
    step(1);
    check_lit("drop_dark", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    step(4);
    enable = 1'b1;
    step(2);
    check_lit("reenable_digit0_7", 4'b1110, 7'b1111000, 1'b1, 1'b0);

    // Hex glyphs over several frames.
    digits = 16'hFEDC;
    step(16);
    check_lit("hex_slot0_C", 4'b1110, 7'b1000110, 1'b1, 1'b0);
    step(4);
    check_lit("hex_slot1_d", 4'b1101, 7'b0100001, 1'b1, 1'b0);
    step(4);
    check_lit("hex_slot2_E", 4'b1011, 7'b0000110, 1'b1, 1'b0);
    step(4);
    check_lit("hex_slot3_F", 4'b0111, 7'b0001110, 1'b1, 1'b0);
    step(40);

    // Randomized traffic; the per-cycle model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      digits     = 16'($urandom);
      dp_mask    = 4'($urandom);
      blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      enable     = ($urandom_range(0, 79) != 0);
      rst        = ($urandom_range(0, 199) == 0);
      step(1);
    end

    rst = 1'b0; enable = 1'b0;
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
